full_adder_cell: RTL and testbench

- Parameterised ripple-carry full adder. WIDTH=1 gives the classic 1-bit full adder used as the building block of the multi-bit adders in the ALU datapath.
- Provides two result paths:
  - a combinational path, with ports in the same order as the classic 1-bit cell;
  - a one-cycle registered path with a valid flag, for pipelined ALU stages.
- Also reports signed overflow.

---
 rtl/full_adder_cell.sv | 78 +++++++
 tb/tb_full_adder_cell.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_cell.sv
// Parameterised ripple-carry adder with a combinational result and a one-cycle registered result.
// Define FULL_ADDER_GP_EN to expose per-bit and block-level generate/propagate terms.
module full_adder_cell #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
`ifdef FULL_ADDER_GP_EN
    ,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic             gg,
    output logic             pg
`endif
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    // One classic full-adder cell per bit; gate-level form keeps X confined to affected bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
        end
    endgenerate

    assign cout = c[WIDTH];
    assign ovf  = c[WIDTH] ^ c[WIDTH-1];

`ifdef FULL_ADDER_GP_EN
    // Second carry chain with a forced-zero carry-in gives the block generate term.
    logic [WIDTH:0] gc;

    assign gc[0] = 1'b0;

    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_gp
            assign g[gi]    = a[gi] & b[gi];
            assign p[gi]    = a[gi] ^ b[gi];
            assign gc[gi+1] = g[gi] | (p[gi] & gc[gi]);
        end
    endgenerate

    assign pg = &p;
    assign gg = gc[WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q  <= sum;
                cout_q <= cout;
                ovf_q  <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_cell.sv
// Self-checking bench for full_adder_cell: a 1-bit and a 6-bit instance checked against
// an integer-arithmetic reference model, plus registered-path and reset scenarios.
module tb_full_adder_cell;

    logic clk;
    logic rst_n;

    logic       a1, b1, cin1, iv1;
    logic       sum1, cout1, ovf1, sum1_q, cout1_q, ovf1_q, ov1;

    logic [5:0] a6, b6;
    logic       cin6, iv6;
    logic [5:0] sum6, sum6_q;
    logic       cout6, ovf6, cout6_q, ovf6_q, ov6;

`ifdef FULL_ADDER_GP_EN
    logic       g1, p1, gg1, pg1;
    logic [5:0] g6, p6;
    logic       gg6, pg6;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    full_adder_cell #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .in_valid(iv1),
        .sum_q(sum1_q), .cout_q(cout1_q), .ovf_q(ovf1_q), .out_valid(ov1)
`ifdef FULL_ADDER_GP_EN
        , .g(g1), .p(p1), .gg(gg1), .pg(pg1)
`endif
    );

    full_adder_cell #(.WIDTH(6)) u_w6 (
        .clk(clk), .rst_n(rst_n), .a(a6), .b(b6), .cin(cin6),
        .sum(sum6), .cout(cout6), .ovf(ovf6), .in_valid(iv6),
        .sum_q(sum6_q), .cout_q(cout6_q), .ovf_q(ovf6_q), .out_valid(ov6)
`ifdef FULL_ADDER_GP_EN
        , .g(g6), .p(p6), .gg(gg6), .pg(pg6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned total gives sum/cout; signed range test gives overflow.
    function automatic void ref_add(input int w, input longint av, input longint bv, input bit ci,
                                    output longint s, output bit co, output bit ov);
        longint tot, half, sa, sb, ss;
        tot  = av + bv + longint'(ci);
        half = longint'(1) << (w - 1);
        s    = tot & ((longint'(1) << w) - 1);
        co   = ((tot >> w) & 1) != 0;
        sa   = (av >= half) ? av - 2 * half : av;
        sb   = (bv >= half) ? bv - 2 * half : bv;
        ss   = sa + sb + longint'(ci);
        ov   = (ss < -half) || (ss > half - 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
        a6 = 0; b6 = 0; cin6 = 0; iv6 = 0;
        #1;
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_w6: got q=%b cout_q=%b ovf_q=%b valid=%b, want all 0", sum6_q, cout6_q, ovf6_q, ov6);
        end
        tests_run++;
        if ({sum1_q, cout1_q, ovf1_q, ov1} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_w1: got %b%b%b%b, want 0000", sum1_q, cout1_q, ovf1_q, ov1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_truth_table();
        longint s; bit co, ov;
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            #1;
            ref_add(1, longint'(a1), longint'(b1), cin1, s, co, ov);
            tests_run++;
            if ({sum1, cout1, ovf1} !== {s[0], co, ov}) begin
                tests_failed++;
                $display("FAIL truth_w1 a=%b b=%b cin=%b: got sum=%b cout=%b ovf=%b, want %b %b %b",
                         a1, b1, cin1, sum1, cout1, ovf1, s[0], co, ov);
            end
            $display("[TB] w1 a=%b b=%b cin=%b -> sum=%b cout=%b ovf=%b", a1, b1, cin1, sum1, cout1, ovf1);
        end
    endtask

    task automatic test_directed_w6();
        logic [5:0] ta [4] = '{6'b011110, 6'b111111, 6'b000000, 6'b111110};
        logic [5:0] tb [4] = '{6'b000011, 6'b100000, 6'b000000, 6'b111111};
        logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] te [4] = '{{6'b100001, 1'b0, 1'b1}, {6'b100000, 1'b1, 1'b0},
                               {6'b000000, 1'b0, 1'b0}, {6'b111101, 1'b1, 1'b0}};
        for (int i = 0; i < 4; i++) begin
            a6 = ta[i]; b6 = tb[i]; cin6 = tc[i];
            #1;
            tests_run++;
            if ({sum6, cout6, ovf6} !== te[i]) begin
                tests_failed++;
                $display("FAIL directed_w6[%0d]: got sum=%b cout=%b ovf=%b, want %b", i, sum6, cout6, ovf6, te[i]);
            end
            $display("[TB] w6 a=%b b=%b cin=%b -> sum=%b cout=%b ovf=%b", a6, b6, cin6, sum6, cout6, ovf6);
        end
        // Full carry ripple boundary.
        a6 = 6'h3f; b6 = 6'h00; cin6 = 1'b1;
        #1;
        tests_run++;
        if ({sum6, cout6} !== 7'b000000_1) begin
            tests_failed++;
            $display("FAIL ripple_w6: got sum=%b cout=%b, want 000000 1", sum6, cout6);
        end
        a6 = 6'h3f; b6 = 6'h3f; cin6 = 1'b1;
        #1;
        tests_run++;
        if ({sum6, cout6} !== 7'b111111_1) begin
            tests_failed++;
            $display("FAIL allones_w6: got sum=%b cout=%b, want 111111 1", sum6, cout6);
        end
    endtask

    task automatic test_random_comb();
        longint s; bit co, ov;
        for (int i = 0; i < 40; i++) begin
            a6 = 6'($urandom); b6 = 6'($urandom); cin6 = 1'($urandom);
            #1;
            ref_add(6, longint'(a6), longint'(b6), cin6, s, co, ov);
            tests_run++;
            if ({sum6, cout6, ovf6} !== {s[5:0], co, ov}) begin
                tests_failed++;
                $display("FAIL rand_comb a=%h b=%h cin=%b: got %h %b %b, want %h %b %b",
                         a6, b6, cin6, sum6, cout6, ovf6, s[5:0], co, ov);
            end
`ifdef FULL_ADDER_GP_EN
            begin
                longint s0; bit c0, o0;
                ref_add(6, longint'(a6), longint'(b6), 1'b0, s0, c0, o0);
                tests_run++;
                if ({g6, p6, gg6, pg6} !== {a6 & b6, a6 ^ b6, c0, (a6 ^ b6) == 6'h3f}) begin
                    tests_failed++;
                    $display("FAIL rand_gp a=%h b=%h: got g=%h p=%h gg=%b pg=%b", a6, b6, g6, p6, gg6, pg6);
                end
            end
`endif
        end
        $display("[TB] random combinational sweep done");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a6 = 6'b011110; b6 = 6'b000011; cin6 = 1'b0; iv6 = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== {6'b100001, 1'b0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_first: got q=%b cout_q=%b ovf_q=%b valid=%b, want 100001 0 1 1", sum6_q, cout6_q, ovf6_q, ov6);
        end
        a6 = 6'b111111; b6 = 6'b100000; cin6 = 1'b1; iv6 = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== {6'b100000, 1'b1, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL b2b_second: got q=%b cout_q=%b ovf_q=%b valid=%b, want 100000 1 0 1", sum6_q, cout6_q, ovf6_q, ov6);
        end
        iv6 = 1'b0; a6 = 6'h15; b6 = 6'h0a; cin6 = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== {6'b100000, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_hold: got q=%b cout_q=%b ovf_q=%b valid=%b, want 100000 1 0 0", sum6_q, cout6_q, ovf6_q, ov6);
        end
        $display("[TB] back-to-back registered pair checked");
    endtask

    task automatic test_random_stream();
        logic [5:0] exp_s = sum6_q;
        logic       exp_c = cout6_q, exp_o = ovf6_q, exp_v = ov6;
        longint s; bit co, ov;
        for (int i = 0; i < 60; i++) begin
            a6 = 6'($urandom); b6 = 6'($urandom); cin6 = 1'($urandom);
            iv6 = ($urandom_range(0, 2) != 0);
            ref_add(6, longint'(a6), longint'(b6), cin6, s, co, ov);
            if (iv6) begin
                exp_s = s[5:0]; exp_c = co; exp_o = ov;
            end
            exp_v = iv6;
            @(negedge clk);
            tests_run++;
            if ({sum6_q, cout6_q, ovf6_q, ov6} !== {exp_s, exp_c, exp_o, exp_v}) begin
                tests_failed++;
                $display("FAIL stream[%0d]: got %h %b %b %b, want %h %b %b %b",
                         i, sum6_q, cout6_q, ovf6_q, ov6, exp_s, exp_c, exp_o, exp_v);
            end
        end
        iv6 = 1'b0;
        $display("[TB] random registered stream done");
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a6 = 6'b111110; b6 = 6'b111111; cin6 = 1'b0; iv6 = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== 9'd0) begin
            tests_failed++;
            $display("FAIL midreset_async: got %b %b %b %b, want all 0", sum6_q, cout6_q, ovf6_q, ov6);
        end
        tests_run++;
        if ({sum6, cout6, ovf6} !== {6'b111101, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL midreset_comb: got sum=%b cout=%b ovf=%b, want 111101 1 0", sum6, cout6, ovf6);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({sum6_q, ov6} !== 7'd0) begin
            tests_failed++;
            $display("FAIL midreset_held: got q=%b valid=%b, want 0 0", sum6_q, ov6);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a6 = 6'b011110; b6 = 6'b000011; cin6 = 1'b0; iv6 = 1'b1;
        @(negedge clk);
        iv6 = 1'b0;
        tests_run++;
        if ({sum6_q, cout6_q, ovf6_q, ov6} !== {6'b100001, 1'b0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL midreset_resume: got %b %b %b %b, want 100001 0 1 1", sum6_q, cout6_q, ovf6_q, ov6);
        end
        $display("[TB] mid-stream reset checked");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_truth_table();
        test_directed_w6();
        test_random_comb();
        test_back_to_back();
        test_random_stream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
